// File: rtl/opseq_pkg.sv
// Shared state encoding and datapath widths for the ALU operand sequencer.
package opseq_pkg;

  localparam int OPND_W = 4;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    S_WAIT_A  = 2'd0,
    S_WAIT_B  = 2'd1,
    S_WAIT_OP = 2'd2,
    S_ISSUE   = 2'd3
  } opseq_state_e;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_i,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // The level flips on the cycle the count would reach DEBOUNCE_CYCLES;
  // the press pulse is registered alongside that flip.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and select from shared switches on debounced presses and issues
// them with valid/ready. Optional clear key enabled by `define OPSEQ_CLEAR_EN.
//
// state     | meaning
// S_WAIT_A  | next press captures data_sw into A
// S_WAIT_B  | next press captures data_sw into B
// S_WAIT_OP | next press captures op_sw into select
// S_ISSUE   | op_valid high, waiting for op_ready
module alu_operand_sequencer
  import opseq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [OPND_W-1:0] data_sw,
  input  logic [SEL_W-1:0]  op_sw,
  input  logic              key_load_n,
`ifdef OPSEQ_CLEAR_EN
  input  logic              key_clr_n,
`endif
  input  logic              op_ready,
  output logic [OPND_W-1:0] a_out,
  output logic [OPND_W-1:0] b_out,
  output logic [SEL_W-1:0]  select_out,
  output logic              op_valid,
  output logic [1:0]        state_out
);

  logic load_press;
  logic clr_press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_db (
    .clk    (clk),
    .resetn (resetn),
    .key_n_i(key_load_n),
    .press_o(load_press)
  );

`ifdef OPSEQ_CLEAR_EN
  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr_db (
    .clk    (clk),
    .resetn (resetn),
    .key_n_i(key_clr_n),
    .press_o(clr_press)
  );
`else
  assign clr_press = 1'b0;
`endif

  opseq_state_e      state_q;
  logic [OPND_W-1:0] a_q, b_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;

  // Clear takes priority over everything, so a coincident load press is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr_press) begin
      state_q <= S_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT_A: if (load_press) begin
          a_q     <= data_sw;
          state_q <= S_WAIT_B;
        end
        S_WAIT_B: if (load_press) begin
          b_q     <= data_sw;
          state_q <= S_WAIT_OP;
        end
        S_WAIT_OP: if (load_press) begin
          sel_q   <= op_sw;
          state_q <= S_ISSUE;
          valid_q <= 1'b1;
        end
        S_ISSUE: if (op_ready) begin
          state_q <= S_WAIT_A;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_WAIT_A;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign select_out = sel_q;
  assign op_valid   = valid_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with DEBOUNCE_CYCLES=4.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] data_sw;
  logic [2:0] op_sw;
  logic       key_load_n;
`ifdef OPSEQ_CLEAR_EN
  logic       key_clr_n;
`endif
  logic       op_ready;
  logic [3:0] a_out, b_out;
  logic [2:0] select_out;
  logic       op_valid;
  logic [1:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .data_sw   (data_sw),
    .op_sw     (op_sw),
    .key_load_n(key_load_n),
`ifdef OPSEQ_CLEAR_EN
    .key_clr_n (key_clr_n),
`endif
    .op_ready  (op_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .select_out(select_out),
    .op_valid  (op_valid),
    .state_out (state_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic v,
                         input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    n_tests++;
    assert (state_out === st) else begin
      n_fail++;
      $error("FAIL %s.state: observed %0d expected %0d", tag, state_out, st);
    end
    n_tests++;
    assert (op_valid === v) else begin
      n_fail++;
      $error("FAIL %s.op_valid: observed %0b expected %0b", tag, op_valid, v);
    end
    n_tests++;
    assert (a_out === a) else begin
      n_fail++;
      $error("FAIL %s.a_out: observed %0h expected %0h", tag, a_out, a);
    end
    n_tests++;
    assert (b_out === b) else begin
      n_fail++;
      $error("FAIL %s.b_out: observed %0h expected %0h", tag, b_out, b);
    end
    n_tests++;
    assert (select_out === s) else begin
      n_fail++;
      $error("FAIL %s.select_out: observed %0h expected %0h", tag, select_out, s);
    end
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] op);
    data_sw    = d;
    op_sw      = op;
    key_load_n = 1'b0;
    repeat (8) tick();
    key_load_n = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    resetn     = 1'b0;
    key_load_n = 1'b1;
`ifdef OPSEQ_CLEAR_EN
    key_clr_n  = 1'b1;
`endif
    op_ready   = 1'b1;
    data_sw    = 4'h0;
    op_sw      = 3'b000;
    #12;
    chk_out("reset", 2'd0, 1'b0, 4'h0, 4'h0, 3'd0);
    resetn = 1'b1;
    tick();

    // key first sampled low at edge 1: no capture by edge 6, capture at edge 7
    data_sw    = 4'h3;
    key_load_n = 1'b0;
    repeat (6) tick();
    chk_out("lat_e6", 2'd0, 1'b0, 4'h0, 4'h0, 3'd0);
    tick();
    chk_out("lat_e7", 2'd1, 1'b0, 4'h3, 4'h0, 3'd0);
    key_load_n = 1'b1;
    repeat (8) tick();

    press(4'h5, 3'b000);
    chk_out("b_cap", 2'd2, 1'b0, 4'h3, 4'h5, 3'd0);

    // op_ready already high: exactly one op_valid cycle
    op_sw      = 3'b001;
    key_load_n = 1'b0;
    repeat (7) tick();
    chk_out("issue", 2'd3, 1'b1, 4'h3, 4'h5, 3'd1);
    tick();
    chk_out("handshake", 2'd0, 1'b0, 4'h3, 4'h5, 3'd1);
    key_load_n = 1'b1;
    repeat (8) tick();
    chk_out("post_hs", 2'd0, 1'b0, 4'h3, 4'h5, 3'd1);

    // 3-cycle glitch must be rejected
    data_sw    = 4'hE;
    key_load_n = 1'b0;
    repeat (3) tick();
    key_load_n = 1'b1;
    repeat (8) tick();
    chk_out("glitch3", 2'd0, 1'b0, 4'h3, 4'h5, 3'd1);

    // exactly DEBOUNCE_CYCLES low cycles is accepted
    data_sw    = 4'h7;
    key_load_n = 1'b0;
    repeat (4) tick();
    key_load_n = 1'b1;
    repeat (10) tick();
    chk_out("low4", 2'd1, 1'b0, 4'h7, 4'h5, 3'd1);

    // bounce train 0-1-0-1 then steady low: one capture only
    data_sw    = 4'hA;
    key_load_n = 1'b0; tick();
    key_load_n = 1'b1; tick();
    key_load_n = 1'b0; tick();
    key_load_n = 1'b1; tick();
    key_load_n = 1'b0;
    repeat (10) tick();
    key_load_n = 1'b1;
    repeat (8) tick();
    chk_out("bounce", 2'd2, 1'b0, 4'h7, 4'hA, 3'd1);

    // backpressure with an extra press during the stall
    op_ready   = 1'b0;
    op_sw      = 3'b110;
    key_load_n = 1'b0;
    repeat (7) tick();
    chk_out("bp_entry", 2'd3, 1'b1, 4'h7, 4'hA, 3'd6);
    data_sw = 4'h9;
    op_sw   = 3'b010;
    for (int i = 0; i < 24; i++) begin
      key_load_n = (i >= 8 && i < 16) ? 1'b0 : 1'b1;
      tick();
      chk_out("bp_stall", 2'd3, 1'b1, 4'h7, 4'hA, 3'd6);
    end
    op_ready = 1'b1;
    tick();
    chk_out("bp_done", 2'd0, 1'b0, 4'h7, 4'hA, 3'd6);

    // asynchronous reset between edges
    press(4'hF, 3'b000);
    chk_out("pre_rst", 2'd1, 1'b0, 4'hF, 4'hA, 3'd6);
    #3;
    resetn = 1'b0;
    #1;
    chk_out("async_rst", 2'd0, 1'b0, 4'h0, 4'h0, 3'd0);
    #2;
    resetn = 1'b1;
    tick();
    press(4'h2, 3'b000);
    chk_out("post_rst", 2'd1, 1'b0, 4'h2, 4'h0, 3'd0);

`ifdef OPSEQ_CLEAR_EN
    press(4'h4, 3'b000);
    op_ready   = 1'b0;
    op_sw      = 3'b101;
    key_load_n = 1'b0;
    repeat (7) tick();
    chk_out("clr_pre", 2'd3, 1'b1, 4'h2, 4'h4, 3'd5);
    key_load_n = 1'b1;
    repeat (8) tick();
    key_clr_n = 1'b0;
    repeat (7) tick();
    chk_out("clr_issue", 2'd0, 1'b0, 4'h0, 4'h0, 3'd0);
    key_clr_n = 1'b1;
    repeat (8) tick();
    op_ready   = 1'b1;
    data_sw    = 4'hC;
    key_clr_n  = 1'b0;
    key_load_n = 1'b0;
    repeat (8) tick();
    key_clr_n  = 1'b1;
    key_load_n = 1'b1;
    repeat (8) tick();
    chk_out("clr_vs_load", 2'd0, 1'b0, 4'h0, 4'h0, 3'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
